// File: rtl/add32_sequencer_pkg.sv
// Shared types and constants for the multi-word add/subtract sequencer.
package add32_sequencer_pkg;

  localparam int unsigned WORD = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add32_sequencer_if.sv
// Request/result bundle between the ALU control and the sequencer.
interface add32_sequencer_if #(
  parameter int unsigned NWORDS = 2
) ();
  localparam int unsigned W = 16 * NWORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  logic         overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, carry_out, zero, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, carry_out, zero, overflow
  );
endinterface

// File: rtl/add32_sequencer_adder16.sv
// Single 16-bit adder slice with carry in/out, shared across all words.
module Adder16bits (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        CY_In,
  output logic [15:0] Sum,
  output logic        CY_Out
);
  logic [16:0] full;

  always_comb begin
    full   = {1'b0, A} + {1'b0, B} + {16'd0, CY_In};
    Sum    = full[15:0];
    CY_Out = full[16];
  end
endmodule

// File: rtl/add32_sequencer.sv
// Multi-cycle wide add/subtract: feeds one 16-bit adder LSW first, chaining carry
// through a register; flags are registered with the top word so they arrive with done.
module add32_sequencer
  import add32_sequencer_pkg::*;
#(
  parameter int unsigned NWORDS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  add32_sequencer_if.slave    bus
);
  localparam int unsigned W    = WORD * NWORDS;
  localparam int unsigned IDXW = $clog2(NWORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_eff_q, b_eff_d;
  logic [W-1:0]    result_q, result_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            carry_out_q, carry_out_d;
  logic            zero_q, zero_d;
  logic            overflow_q, overflow_d;

  int unsigned     base;
  logic [15:0]     word_a, word_b, sum;
  logic            cy_out;
  logic            accept;

  always_comb begin
    base   = 32'(idx_q) * WORD;
    word_a = a_q[base +: WORD];
    word_b = b_eff_q[base +: WORD];
  end

  Adder16bits u_add (
    .A      (word_a),
    .B      (word_b),
    .CY_In  (carry_q),
    .Sum    (sum),
    .CY_Out (cy_out)
  );

  assign accept = bus.start && (state_q != ST_RUN);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_eff_d     = b_eff_q;
    result_d    = result_q;
    busy_d      = busy_q;
    done_d      = done_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        done_d = 1'b0;
        if (accept) begin
          // Subtraction is A + ~B + 1: invert B once here and seed the carry with sub.
          state_d     = ST_RUN;
          a_d         = bus.a;
          b_eff_d     = bus.b ^ {W{bus.sub}};
          idx_d       = '0;
          carry_d     = bus.sub;
          result_d    = '0;
          carry_out_d = 1'b0;
          zero_d      = 1'b0;
          overflow_d  = 1'b0;
          busy_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        result_d[base +: WORD] = sum;
        carry_d                = cy_out;
        idx_d                  = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          carry_out_d = cy_out;
          zero_d      = (result_d == '0);
          overflow_d  = (a_q[W-1] == b_eff_q[W-1]) && (sum[15] != a_q[W-1]);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_eff_q     <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_eff_q     <= b_eff_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_add32_sequencer.sv
// Directed bench for add32_sequencer (NWORDS=2) with a result scoreboard.
module tb_add32_sequencer;
  localparam int unsigned NWORDS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add32_sequencer_if #(.NWORDS(NWORDS)) bus ();

  add32_sequencer #(.NWORDS(NWORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] result;
    logic        carry;
    logic        zero;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [31:0] be;
    logic [32:0] full;
    exp_t        e;
    be       = sub ? ~b : b;
    full     = {1'b0, a} + {1'b0, be} + {32'd0, sub};
    e.result = full[31:0];
    e.carry  = full[32];
    e.zero   = (full[31:0] == 32'd0);
    e.ovf    = (a[31] == be[31]) && (full[31] != a[31]);
    return e;
  endfunction

  // Called #1 after a posedge; start is sampled at the next edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input bit push, input bit hold);
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    bus.start = 1'b1;
    if (push) sb.push_back(model(a, b, sub));
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    check("busy_after_accept", bus.busy, 1);
    check("done_after_accept", bus.done, 0);
  endtask

  task automatic wait_done(input string tag, input int unsigned lat);
    int unsigned n    = 0;
    bit          seen = 1'b0;
    exp_t        e;
    while (n < 20 && !seen) begin
      @(posedge clk); #1;
      n++;
      seen = (bus.done === 1'b1);
    end
    check({tag, "_done"}, seen, 1);
    if (seen) begin
      check({tag, "_latency"}, n, lat);
      check({tag, "_busy_low"}, bus.busy, 0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
      end else begin
        e = sb.pop_front();
        check({tag, "_result"}, bus.result, e.result);
        check({tag, "_carry"}, bus.carry_out, e.carry);
        check({tag, "_zero"}, bus.zero, e.zero);
        check({tag, "_ovf"}, bus.overflow, e.ovf);
      end
    end
  endtask

  task automatic expect_quiet(input string tag, input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check({tag, "_no_done"}, bus.done, 0);
      check({tag, "_no_busy"}, bus.busy, 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) check("busy_done_exclusive", bus.busy & bus.done, 0);
  end

  initial begin
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_carry", bus.carry_out, 0);
    check("rst_zero", bus.zero, 0);
    check("rst_ovf", bus.overflow, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    drive(32'h0000FFFF, 32'h00000001, 1'b0, 1, 0);
    wait_done("t1_carry_word", NWORDS);
    drive(32'hFFFFFFFF, 32'h00000001, 1'b0, 1, 0);
    wait_done("t2_wrap_zero", NWORDS);
    drive(32'd5, 32'd7, 1'b1, 1, 0);
    wait_done("t3_borrow", NWORDS);
    drive(32'd7, 32'd5, 1'b1, 1, 0);
    wait_done("t3_no_borrow", NWORDS);
    drive(32'h7FFFFFFF, 32'd1, 1'b0, 1, 0);
    wait_done("t4_ovf_add", NWORDS);
    drive(32'h80000000, 32'd1, 1'b1, 1, 0);
    wait_done("t4_ovf_sub", NWORDS);

    // Start re-asserted with other operands while running must be dropped.
    drive(32'h12345678, 32'h11111111, 1'b0, 1, 0);
    bus.a     = 32'hDEADBEEF;
    bus.b     = 32'h0BADF00D;
    bus.sub   = 1'b1;
    bus.start = 1'b1;
    wait_done("t5_ignored", NWORDS);
    bus.start = 1'b0;
    expect_quiet("t5_after_ignore", 3);

    // Start held through DONE: the second op follows with no idle gap.
    drive(32'h0000A000, 32'h00006000, 1'b0, 1, 1);
    bus.a   = 32'h00000010;
    bus.b   = 32'h00000020;
    bus.sub = 1'b1;
    sb.push_back(model(32'h00000010, 32'h00000020, 1'b1));
    wait_done("t5_b2b_first", NWORDS);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("t5_b2b_busy", bus.busy, 1);
    check("t5_b2b_done_drop", bus.done, 0);
    wait_done("t5_b2b_second", NWORDS);

    // Reset in the first RUN cycle aborts without a done pulse.
    drive(32'h00001111, 32'h00002222, 1'b0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t6_abort_busy", bus.busy, 0);
    check("t6_abort_done", bus.done, 0);
    check("t6_abort_result", bus.result, 0);
    rst_n = 1'b1;
    expect_quiet("t6_after_abort", 4);
    drive(32'h00010001, 32'h0000FFFF, 1'b0, 1, 0);
    wait_done("t6_recover", NWORDS);

    for (int i = 0; i < 6; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1, 0);
      wait_done("rand_op", NWORDS);
    end

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
